rib_matrix: RTL and testbench

// - Parametrised successor to the fixed 4-master/8-slave RIB: N_MST x N_SLV shared-bus matrix.
// - Adds lock-until-ready arbitration for multi-cycle slaves, per-master hold, decode error and
//   a timeout watchdog.
// - Sits between the masters (core EX, core PC fetch, JTAG, UART debug) and the SoC peripherals.
// - Slave select = addr[AW-1 -: SEL_W]; slave k owns region k << (AW-SEL_W).

---
 rtl/rib_matrix.sv | 219 +++++++++++++++++++++
 tb/tb_rib_matrix.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rib_matrix.sv
// rib_matrix: N_MST x N_SLV shared-bus matrix with lock-until-ready arbitration.
// Optional round-robin arbitration: define RIB_RR_ARB_EN (default is fixed priority).
module rib_matrix #(
    parameter int N_MST   = 4,
    parameter int N_SLV   = 8,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [N_MST-1:0]    m_req_i,
    input  logic [N_MST-1:0]    m_we_i,
    input  logic [N_MST*AW-1:0] m_addr_i,
    input  logic [N_MST*DW-1:0] m_wdata_i,
    output logic [N_MST*DW-1:0] m_rdata_o,
    output logic [N_MST-1:0]    m_ready_o,
    output logic [N_MST-1:0]    m_err_o,
    output logic [N_MST-1:0]    hold_o,
    output logic [N_SLV-1:0]    s_req_o,
    output logic [N_SLV-1:0]    s_we_o,
    output logic [N_SLV*AW-1:0] s_addr_o,
    output logic [N_SLV*DW-1:0] s_wdata_o,
    input  logic [N_SLV*DW-1:0] s_rdata_i,
    input  logic [N_SLV-1:0]    s_ready_i
);

    localparam int MW = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int OW = AW - SEL_W;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e          state_q, state_d;
    logic [MW-1:0]   owner_q, owner_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    logic            gnt_vld, act;
    logic [MW-1:0]   gnt;
    logic [AW-1:0]   g_addr;
    logic [DW-1:0]   g_wdata;
    logic            g_we;
    logic [SEL_W-1:0] sel;
    logic            dec_err, sel_rdy;
    logic [DW-1:0]   sel_rdata;
    logic            fire_s, rdy, err, pass;

`ifdef RIB_RR_ARB_EN
    logic [MW-1:0]   rr_q, rr_d;
`endif

    // Pick the master that owns the bus this cycle (locked owner while BUSY)
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        if (state_q == BUSY) begin
            gnt = owner_q;
            for (int i = 0; i < N_MST; i++)
                if (owner_q == MW'(i)) gnt_vld = m_req_i[i];
        end else begin
`ifdef RIB_RR_ARB_EN
            for (int k = 0; k < N_MST; k++)
                for (int i = 0; i < N_MST; i++)
                    if (!gnt_vld && m_req_i[i] &&
                        ((int'(rr_q) + k) % N_MST) == i) begin
                        gnt_vld = 1'b1;
                        gnt     = MW'(i);
                    end
`else
            for (int i = 0; i < N_MST; i++)
                if (m_req_i[i]) begin
                    gnt_vld = 1'b1;
                    gnt     = MW'(i);
                end
`endif
        end
    end

    assign act = gnt_vld & rst_ni;

    // Route the granted master's request and decode its target slave
    always_comb begin
        g_addr  = '0;
        g_wdata = '0;
        g_we    = 1'b0;
        for (int i = 0; i < N_MST; i++)
            if (gnt == MW'(i)) begin
                g_addr  = m_addr_i[i*AW +: AW];
                g_wdata = m_wdata_i[i*DW +: DW];
                g_we    = m_we_i[i];
            end
        sel       = g_addr[AW-1 -: SEL_W];
        dec_err   = 1'b1;
        sel_rdy   = 1'b0;
        sel_rdata = '0;
        for (int k = 0; k < N_SLV; k++)
            if (sel == SEL_W'(k)) begin
                dec_err   = 1'b0;
                sel_rdy   = s_ready_i[k];
                sel_rdata = s_rdata_i[k*DW +: DW];
            end
    end

    // Transfer FSM: zero-wait completion in IDLE, locked wait with watchdog in BUSY
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        tmo_d   = tmo_q;
        fire_s  = 1'b0;
        rdy     = 1'b0;
        err     = 1'b0;
        pass    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (act) begin
                    if (dec_err) begin
                        rdy = 1'b1;
                        err = 1'b1;
                    end else begin
                        fire_s = 1'b1;
                        if (sel_rdy) begin
                            rdy  = 1'b1;
                            pass = 1'b1;
                        end else begin
                            state_d = BUSY;
                            owner_d = gnt;
                            tmo_d   = TW'(1);
                        end
                    end
                end
            end
            BUSY: begin
                if (!act) begin
                    state_d = IDLE;
                    tmo_d   = '0;
                end else if (dec_err) begin
                    rdy     = 1'b1;
                    err     = 1'b1;
                    state_d = IDLE;
                    tmo_d   = '0;
                end else begin
                    fire_s = 1'b1;
                    if (sel_rdy) begin
                        rdy     = 1'b1;
                        pass    = 1'b1;
                        state_d = IDLE;
                        tmo_d   = '0;
                    end else if (tmo_q == TMO_MAX) begin
                        rdy     = 1'b1;
                        err     = 1'b1;
                        state_d = IDLE;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Drive master and slave side outputs; everything idles at 0
    always_comb begin
        m_ready_o = '0;
        m_err_o   = '0;
        m_rdata_o = '0;
        hold_o    = '0;
        s_req_o   = '0;
        s_we_o    = '0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        for (int i = 0; i < N_MST; i++) begin
            hold_o[i] = rst_ni & m_req_i[i] & ~(act & (gnt == MW'(i)));
            if (gnt == MW'(i)) begin
                m_ready_o[i] = rdy;
                m_err_o[i]   = err;
                if (pass) m_rdata_o[i*DW +: DW] = sel_rdata;
            end
        end
        for (int k = 0; k < N_SLV; k++)
            if (fire_s && sel == SEL_W'(k)) begin
                s_req_o[k]             = 1'b1;
                s_we_o[k]              = g_we;
                s_addr_o[k*AW +: AW]   = {{SEL_W{1'b0}}, g_addr[OW-1:0]};
                s_wdata_o[k*DW +: DW]  = g_wdata;
            end
    end

`ifdef RIB_RR_ARB_EN
    // Advance the round-robin pointer past the master whose transfer just ended
    always_comb begin
        rr_d = rr_q;
        if (rdy || (rst_ni && state_q == BUSY && !gnt_vld))
            rr_d = (gnt == MW'(N_MST - 1)) ? '0 : gnt + MW'(1);
    end
`endif

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
            tmo_q   <= '0;
`ifdef RIB_RR_ARB_EN
            rr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            tmo_q   <= tmo_d;
`ifdef RIB_RR_ARB_EN
            rr_q    <= rr_d;
`endif
        end
    end

endmodule

// File: tb/tb_rib_matrix.sv
// tb_rib_matrix: vector table plus multi-cycle sequences for rib_matrix.
// Expected values are queued on drive and compared when outputs settle.
module tb_rib_matrix;

    localparam int NM  = 4;
    localparam int NS  = 8;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NM-1:0]    m_req, m_we, m_ready, m_err, hold;
    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wdata, m_rdata;
    logic [NS-1:0]    s_req, s_we, s_ready;
    logic [NS*AW-1:0] s_addr;
    logic [NS*DW-1:0] s_wdata, s_rdata;

    always #5 clk = ~clk;

    rib_matrix #(
        .N_MST(NM), .N_SLV(NS), .AW(AW), .DW(DW), .SEL_W(4), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr),
        .m_wdata_i(m_wdata), .m_rdata_o(m_rdata), .m_ready_o(m_ready),
        .m_err_o(m_err), .hold_o(hold),
        .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr),
        .s_wdata_o(s_wdata), .s_rdata_i(s_rdata), .s_ready_i(s_ready)
    );

    typedef struct {
        int          id;
        logic [3:0]  req, we;
        logic [31:0] a0, a1, a2, a3;
        logic [7:0]  srdy;
        logic [3:0]  rdy, err, hold;
        logic [7:0]  sreq, swe;
        int          gm;
        logic [31:0] rd;
        int          si;
        logic [31:0] sa, swd;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int nvec = 0;
    int nmis = 0;
    int g;
    logic [3:0] oh;

    function automatic vec_t mk(input int id, input logic [3:0] req,
        input logic [3:0] we, input logic [31:0] a0, input logic [31:0] a1,
        input logic [31:0] a2, input logic [31:0] a3, input logic [7:0] srdy,
        input logic [3:0] rdy, input logic [3:0] err, input logic [3:0] hld,
        input logic [7:0] sreq, input logic [7:0] swe, input int gm,
        input logic [31:0] rd, input int si, input logic [31:0] sa,
        input logic [31:0] swd);
        vec_t v;
        v.id = id; v.req = req; v.we = we;
        v.a0 = a0; v.a1 = a1; v.a2 = a2; v.a3 = a3; v.srdy = srdy;
        v.rdy = rdy; v.err = err; v.hold = hld; v.sreq = sreq; v.swe = swe;
        v.gm = gm; v.rd = rd; v.si = si; v.sa = sa; v.swd = swd;
        return v;
    endfunction

    function automatic logic [255:0] put(input int idx, input logic [31:0] v);
        logic [255:0] r;
        r = '0;
        if (idx >= 0) r[idx*32 +: 32] = v;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        vec_t e;
        @(negedge clk);
        m_req   = v.req;
        m_we    = v.we;
        m_addr  = {v.a3, v.a2, v.a1, v.a0};
        s_ready = v.srdy;
        sb.push_back(v);
        #2;
        e = sb.pop_front();
        chk($sformatf("v%0d ready", e.id), 256'(m_ready), 256'(e.rdy));
        chk($sformatf("v%0d err", e.id), 256'(m_err), 256'(e.err));
        chk($sformatf("v%0d hold", e.id), 256'(hold), 256'(e.hold));
        chk($sformatf("v%0d s_req", e.id), 256'(s_req), 256'(e.sreq));
        chk($sformatf("v%0d s_we", e.id), 256'(s_we), 256'(e.swe));
        chk($sformatf("v%0d rdata", e.id), 256'(m_rdata), put(e.gm, e.rd));
        chk($sformatf("v%0d s_addr", e.id), s_addr, put(e.si, e.sa));
        chk($sformatf("v%0d s_wdata", e.id), s_wdata, put(e.si, e.swd));
    endtask

    initial begin
        rst_n   = 1'b0;
        m_req   = '0;
        m_we    = '0;
        m_addr  = '0;
        s_ready = '0;
        m_wdata = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
        for (int k = 0; k < NS; k++) s_rdata[k*DW +: DW] = 32'hD000_0000 + 32'(k);

        // in reset: everything 0, even with a request present
        run(mk(0, 4'h0, 4'h0, 0, 0, 0, 0, 8'hFF, 0, 0, 0, 8'h00, 8'h00, -1, 0, -1, 0, 0));
        run(mk(1, 4'h1, 4'h0, 32'h1000_0000, 0, 0, 0, 8'hFF,
               0, 0, 0, 8'h00, 8'h00, -1, 0, -1, 0, 0));
        @(negedge clk);
        m_req = '0;
        rst_n = 1'b1;

`ifndef RIB_RR_ARB_EN
        tbl.push_back(mk(10, 4'h0, 4'h0, 0, 0, 0, 0, 8'hFF,
            4'h0, 4'h0, 4'h0, 8'h00, 8'h00, -1, 0, -1, 0, 0));
        tbl.push_back(mk(11, 4'h1, 4'h0, 32'h1000_0010, 0, 0, 0, 8'hFF,
            4'h1, 4'h0, 4'h0, 8'h02, 8'h00, 0, 32'hD000_0001, 1, 32'h10, 32'hC0DE_0000));
        tbl.push_back(mk(12, 4'h9, 4'h0, 32'h1000_0010, 0, 0, 32'h1000_0100, 8'hFF,
            4'h8, 4'h0, 4'h1, 8'h02, 8'h00, 3, 32'hD000_0001, 1, 32'h100, 32'hC0DE_0003));
        tbl.push_back(mk(13, 4'h1, 4'h0, 32'h1000_0010, 0, 0, 0, 8'hFF,
            4'h1, 4'h0, 4'h0, 8'h02, 8'h00, 0, 32'hD000_0001, 1, 32'h10, 32'hC0DE_0000));
        tbl.push_back(mk(14, 4'h1, 4'h0, 32'hF000_0004, 0, 0, 0, 8'hFF,
            4'h1, 4'h1, 4'h0, 8'h00, 8'h00, 0, 0, -1, 0, 0));
        tbl.push_back(mk(15, 4'h6, 4'h0, 0, 32'h20, 32'h8000_0000, 0, 8'hFF,
            4'h4, 4'h4, 4'h2, 8'h00, 8'h00, 2, 0, -1, 0, 0));
        tbl.push_back(mk(16, 4'h2, 4'h2, 0, 32'h7FFF_FFFC, 0, 0, 8'hFF,
            4'h2, 4'h0, 4'h0, 8'h80, 8'h80, 1, 32'hD000_0007, 7, 32'h0FFF_FFFC, 32'hC0DE_0001));
        tbl.push_back(mk(17, 4'h9, 4'h1, 32'h2000_0008, 0, 0, 32'h9000_0000, 8'hFF,
            4'h8, 4'h8, 4'h1, 8'h00, 8'h00, 3, 0, -1, 0, 0));
        tbl.push_back(mk(18, 4'h4, 4'h4, 0, 0, 32'h6000_0044, 0, 8'hFF,
            4'h4, 4'h0, 4'h0, 8'h40, 8'h40, 2, 32'hD000_0006, 6, 32'h44, 32'hC0DE_0002));
        for (int i = 0; i < tbl.size(); i++) run(tbl[i]);
`endif

        // UART slave 3 waits 3 cycles; m3 arrives in cycle 1 and is held
        run(mk(20, 4'h1, 4'h0, 32'h3000_0000, 0, 0, 0, 8'hF7,
            4'h0, 4'h0, 4'h0, 8'h08, 8'h00, -1, 0, 3, 0, 32'hC0DE_0000));
        for (int c = 0; c < 2; c++)
            run(mk(21 + c, 4'h9, 4'h0, 32'h3000_0000, 0, 0, 32'h1000_0000, 8'hF7,
                4'h0, 4'h0, 4'h8, 8'h08, 8'h00, -1, 0, 3, 0, 32'hC0DE_0000));
        run(mk(23, 4'h9, 4'h0, 32'h3000_0000, 0, 0, 32'h1000_0000, 8'hFF,
            4'h1, 4'h0, 4'h8, 8'h08, 8'h00, 0, 32'hD000_0003, 3, 0, 32'hC0DE_0000));
        run(mk(24, 4'h8, 4'h0, 0, 0, 0, 32'h1000_0000, 8'hFF,
            4'h8, 4'h0, 4'h0, 8'h02, 8'h00, 3, 32'hD000_0001, 1, 0, 32'hC0DE_0003));

        // slave 7 never ready: error in BUSY cycle TMO, late ready ignored
        for (int c = 0; c < TMO; c++)
            run(mk(30 + c, 4'h4, 4'h0, 0, 0, 32'h7000_0000, 0, 8'h7F,
                4'h0, 4'h0, 4'h0, 8'h80, 8'h00, -1, 0, 7, 0, 32'hC0DE_0002));
        run(mk(34, 4'h4, 4'h0, 0, 0, 32'h7000_0000, 0, 8'h7F,
            4'h4, 4'h4, 4'h0, 8'h80, 8'h00, 2, 0, 7, 0, 32'hC0DE_0002));
        run(mk(35, 4'h0, 4'h0, 0, 0, 32'h7000_0000, 0, 8'hFF,
            4'h0, 4'h0, 4'h0, 8'h00, 8'h00, -1, 0, -1, 0, 0));

        // owner abandons a waiting transfer
        for (int c = 0; c < 2; c++)
            run(mk(40 + c, 4'h2, 4'h0, 0, 32'h5000_0000, 0, 0, 8'hDF,
                4'h0, 4'h0, 4'h0, 8'h20, 8'h00, -1, 0, 5, 0, 32'hC0DE_0001));
        run(mk(42, 4'h0, 4'h0, 0, 32'h5000_0000, 0, 0, 8'hDF,
            4'h0, 4'h0, 4'h0, 8'h00, 8'h00, -1, 0, -1, 0, 0));
        run(mk(43, 4'h1, 4'h0, 32'h1000_0004, 0, 0, 0, 8'hFF,
            4'h1, 4'h0, 4'h0, 8'h02, 8'h00, 0, 32'hD000_0001, 1, 32'h4, 32'hC0DE_0000));

        // one-wait write, lower master held meanwhile
        run(mk(45, 4'h8, 4'h8, 0, 0, 0, 32'h4000_0ABC, 8'hEF,
            4'h0, 4'h0, 4'h0, 8'h10, 8'h10, -1, 0, 4, 32'hABC, 32'hC0DE_0003));
        run(mk(46, 4'hA, 4'h8, 0, 32'h8, 0, 32'h4000_0ABC, 8'hFF,
            4'h8, 4'h0, 4'h2, 8'h10, 8'h10, 3, 32'hD000_0004, 4, 32'hABC, 32'hC0DE_0003));
        run(mk(47, 4'h2, 4'h0, 0, 32'h8, 0, 0, 8'hFF,
            4'h2, 4'h0, 4'h0, 8'h01, 8'h00, 1, 32'hD000_0000, 0, 32'h8, 32'hC0DE_0001));

        // asynchronous reset while BUSY
        run(mk(50, 4'h1, 4'h0, 32'h3000_0000, 0, 0, 0, 8'hF7,
            4'h0, 4'h0, 4'h0, 8'h08, 8'h00, -1, 0, 3, 0, 32'hC0DE_0000));
        @(negedge clk);
        #1;
        chk("busy s_req", 256'(s_req), 256'(8'h08));
        rst_n = 1'b0;
        #1;
        chk("rst s_req", 256'(s_req), 256'(0));
        chk("rst ready", 256'(m_ready), 256'(0));
        chk("rst hold", 256'(hold), 256'(0));
        chk("rst s_addr", s_addr, 256'(0));
        chk("rst rdata", 256'(m_rdata), 256'(0));
        @(negedge clk);
        m_req = '0;
        rst_n = 1'b1;
`ifndef RIB_RR_ARB_EN
        run(mk(51, 4'h9, 4'h0, 32'h3000_0000, 0, 0, 32'h1000_0000, 8'hF7,
            4'h8, 4'h0, 4'h1, 8'h02, 8'h00, 3, 32'hD000_0001, 1, 0, 32'hC0DE_0003));
`endif
        run(mk(52, 4'h1, 4'h0, 32'h3000_0000, 0, 0, 0, 8'hFF,
            4'h1, 4'h0, 4'h0, 8'h08, 8'h00, 0, 32'hD000_0003, 3, 0, 32'hC0DE_0000));

        // all masters hammer a single-cycle slave from a fresh reset
        @(negedge clk);
        m_req = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
`ifdef RIB_RR_ARB_EN
            g = c % NM;
`else
            g = NM - 1;
`endif
            oh = 4'(1 << g);
            run(mk(60 + c, 4'hF, 4'h0, 32'h1000_0000, 32'h1000_0000,
                32'h1000_0000, 32'h1000_0000, 8'hFF,
                oh, 4'h0, ~oh, 8'h02, 8'h00, g, 32'hD000_0001, 1, 0,
                32'hC0DE_0000 | 32'(g)));
        end

        @(negedge clk);
        m_req = '0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
